gate_unit_arbiter: RTL and testbench

- Shares one (A OR B) AND C gate unit among NUM_REQ requesters using round-robin arbitration.
- A requester asserts req with its A/B/C operand bits. The arbiter grants one requester and samples its operands into the gate unit.
- It presents the registered result D with the winner's index and holds the result until the consumer acknowledges it.
- Sits between the requesting control blocks and the single shared gate datapath.

---
 rtl/gate_unit_arbiter.sv | 105 ++++++++++
 tb/tb_gate_unit_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered (A|B)&C gate unit among NUM_REQ requesters.
// The winner's operands are latched on the grant edge, and the result is held until res_ack.
module gate_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] a_in,
    input  logic [NUM_REQ-1:0] b_in,
    input  logic [NUM_REQ-1:0] c_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               res_valid,
    output logic               res_d,
    output logic [IDX_W-1:0]   res_id,
    input  logic               res_ack,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } state_t;

    localparam int unsigned         N    = NUM_REQ;
    localparam logic [IDX_W-1:0]    LAST = IDX_W'(NUM_REQ - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             a_lat, b_lat, c_lat;
    int unsigned      cand;

    // Search ptr, ptr+1, ... with a wrap modulo N so non-power-of-two counts never alias
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (found) state_nxt = EVAL;
            EVAL:    state_nxt = HOLD;
            HOLD:    if (res_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_d     <= 1'b0;
            res_id    <= '0;
            ptr       <= '0;
            a_lat     <= 1'b0;
            b_lat     <= 1'b0;
            c_lat     <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= NUM_REQ'(1) << win;
                        a_lat  <= a_in[win];
                        b_lat  <= b_in[win];
                        c_lat  <= c_in[win];
                        res_id <= win;
                    end
                end
                EVAL: begin
                    res_d     <= (a_lat | b_lat) & c_lat;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ack) begin
                        res_valid <= 1'b0;
                        ptr       <= (res_id == LAST) ? '0 : res_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Randomized self-checking bench for gate_unit_arbiter against a transaction-level round-robin model.
module tb_gate_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, a_in, b_in, c_in, gnt;
    logic       res_valid, res_d, res_ack, busy;
    logic [1:0] res_id;

    logic [2:0] req3, a3, b3, c3, gnt3;
    logic       res_valid3, res_d3, res_ack3, busy3;
    logic [1:0] res_id3;

    int n_tests = 0;
    int n_fail  = 0;
    int mptr    = 0;

    gate_unit_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .gnt(gnt), .res_valid(res_valid), .res_d(res_d), .res_id(res_id),
        .res_ack(res_ack), .busy(busy)
    );

    gate_unit_arbiter #(.NUM_REQ(3), .IDX_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .a_in(a3), .b_in(b3), .c_in(c3),
        .gnt(gnt3), .res_valid(res_valid3), .res_d(res_d3), .res_id(res_id3),
        .res_ack(res_ack3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin winner: first requester at or after p, wrapping modulo n
    function automatic int pick(input logic [31:0] r, input int p, input int n);
        for (int o = 0; o < n; o++)
            if (r[(p + o) % n]) return (p + o) % n;
        return -1;
    endfunction

    task automatic scramble();
        req  = 4'($urandom);
        a_in = 4'($urandom);
        b_in = 4'($urandom);
        c_in = 4'($urandom);
    endtask

    task automatic xact(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int stall);
        int   w;
        logic d;
        req = r; a_in = a; b_in = b; c_in = c;
        res_ack = 1'($urandom);
        tick();
        if (r == 4'b0) begin
            check("idle_gnt", gnt, 0);
            check("idle_busy", busy, 0);
            check("idle_valid", res_valid, 0);
            res_ack = 1'b0;
            return;
        end
        w = pick(r, mptr, 4);
        d = (a[w] | b[w]) & c[w];
        check("grant", gnt, 1 << w);
        check("eval_busy", busy, 1);
        check("eval_valid", res_valid, 0);
        scramble();
        res_ack = 1'($urandom);
        tick();
        check("hold_gnt", gnt, 0);
        check("hold_valid", res_valid, 1);
        check("res_d", res_d, d);
        check("res_id", res_id, w);
        res_ack = 1'b0;
        for (int s = 0; s < stall; s++) begin
            scramble();
            tick();
            check("stall_gnt", gnt, 0);
            check("stall_busy", busy, 1);
            check("stall_valid", res_valid, 1);
            check("stall_d", res_d, d);
            check("stall_id", res_id, w);
        end
        res_ack = 1'b1;
        scramble();
        tick();
        check("ack_valid", res_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_gnt", gnt, 0);
        res_ack = 1'b0;
        mptr = (w + 1) % 4;
    endtask

    initial begin
        int w3;
        logic [31:0] gseq;
        rst_n = 1'b0; res_ack = 1'b0;
        req = '0; a_in = '0; b_in = '0; c_in = '0;
        req3 = '0; a3 = '0; b3 = '0; c3 = '0; res_ack3 = 1'b0;
        repeat (2) tick();
        check("rst_gnt", gnt, 0);
        check("rst_valid", res_valid, 0);
        check("rst_d", res_d, 0);
        check("rst_id", res_id, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;

        xact(4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);
        xact(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1);
        xact(4'b0100, 4'b0000, 4'b0100, 4'b0000, 0);
        xact(4'b0100, 4'b0100, 4'b0100, 4'b0100, 2);
        for (int i = 0; i < 5; i++) xact(4'b1111, 4'($urandom), 4'($urandom), 4'($urandom), 0);
        while (mptr != 1) xact(4'b1111, '0, '0, '0, 0);
        xact(4'b0010, 4'b0010, 4'b0000, 4'b0010, 5);
        check("ptr_after_hold", pick(4'b1111, mptr, 4), 2);
        xact(4'b1111, 4'($urandom), 4'($urandom), 4'($urandom), 0);

        // Reset while in EVAL: everything clears at once and the pointer returns to 0
        req = 4'b0100; a_in = 4'b0100; b_in = '0; c_in = 4'b0100;
        tick();
        check("pre_rst_gnt", gnt, 4'b0100);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_valid", res_valid, 0);
        check("async_d", res_d, 0);
        check("async_id", res_id, 0);
        check("async_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        mptr = 0;
        xact(4'b1111, 4'b0001, 4'b0000, 4'b0001, 0);
        xact(4'b1000, 4'b1000, 4'b1000, 4'b1000, 1);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom);
            xact(r, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        // Three-requester instance: pointer must wrap 2 -> 0
        gseq = 0;
        w3 = 0;
        for (int i = 0; i < 7; i++) begin
            req3 = 3'b111; a3 = 3'($urandom); b3 = 3'($urandom); c3 = 3'($urandom);
            tick();
            check("n3_gnt", gnt3, 1 << w3);
            tick();
            check("n3_id", res_id3, w3);
            check("n3_valid", res_valid3, 1);
            check("n3_d", res_d3, (a3[w3] | b3[w3]) & c3[w3]);
            res_ack3 = 1'b1;
            tick();
            res_ack3 = 1'b0;
            check("n3_idle", busy3, 0);
            w3 = (w3 + 1) % 3;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
